// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// 8N1 UART receiver with a 2-flop input synchronizer, break detection and a
// circular receive FIFO drained through a ready/valid pop port.
module uart_rx_fifo #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 1_000_000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              rxd_i,
  output logic [7:0]                        rdata_o,
  output logic                              rvalid_o,
  input  logic                              rready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
  output logic                              ferr_o,
  output logic                              ovf_o,
  input  logic                              clr_err_i
);

  localparam int unsigned CPB = CLK_FREQ / BAUD;
  localparam int unsigned CW  = $clog2(CPB);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned NW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  if (CPB < 4) begin : g_bad_cpb
    $error("uart_rx_fifo: CLK_FREQ/BAUD must be at least 4");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: FIFO_DEPTH must be a power of two and at least 2");
  end

  logic          rx_m, rx_s;
  logic [2:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count;

  logic stop_sample, push, frame_err, pop, full, wr_en, ovf_set;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rxd_i;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_s ? S_IDLE : S_DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            shreg    <= {rx_s, shreg[7:1]};
            if (bit_cnt == 3'd7) state <= S_STOP;
            else                 bit_cnt <= bit_cnt + 3'd1;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            state    <= rx_s ? S_IDLE : S_BREAK;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_BREAK: begin
          // Stay here until the line returns to mark so a held-low line is one error.
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    stop_sample = (state == S_STOP) && (baud_cnt == BIT_LAST);
    push        = stop_sample && rx_s;
    frame_err   = stop_sample && !rx_s;
    pop         = rvalid_o && rready_i;
    full        = (count == FULL_CNT);
    // A pop in the same cycle frees the slot the push needs.
    wr_en       = push && (!full || pop);
    ovf_set     = push && full && !pop;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ferr_o <= 1'b0;
      ovf_o  <= 1'b0;
    end else if (clr_err_i) begin
      ferr_o <= 1'b0;
      ovf_o  <= 1'b0;
    end else begin
      if (frame_err) ferr_o <= 1'b1;
      if (ovf_set)   ovf_o  <= 1'b1;
    end
  end

  assign rdata_o  = mem[rd_ptr];
  assign rvalid_o = (count != '0);
  assign count_o  = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
// Directed bench for uart_rx_fifo at CPB=16: frame timing, glitch rejection,
// framing/break handling, overflow, full-FIFO push+pop and mid-frame reset.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       rxd_i;
  logic [7:0] rdata_o;
  logic       rvalid_o;
  logic       rready_i;
  logic [3:0] count_o;
  logic       ferr_o;
  logic       ovf_o;
  logic       clr_err_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_FREQ  (16_000_000),
    .BAUD      (1_000_000),
    .FIFO_DEPTH(8)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .rxd_i    (rxd_i),
    .rdata_o  (rdata_o),
    .rvalid_o (rvalid_o),
    .rready_i (rready_i),
    .count_o  (count_o),
    .ferr_o   (ferr_o),
    .ovf_o    (ovf_o),
    .clr_err_i(clr_err_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rxd_i = b;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic send_head(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_head(d);
    drive_bit(1'b1);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    rready_i = 1'b1;
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, rvalid_o}, 32'd1);
    check({tag, "_data"}, {24'd0, rdata_o}, {24'd0, exp});
    @(posedge clk);
    #1;
    rready_i = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err_i = 1'b1;
    sync();
    clr_err_i = 1'b0;
  endtask

  initial begin
    rst_ni    = 1'b0;
    rxd_i     = 1'b1;
    rready_i  = 1'b0;
    clr_err_i = 1'b0;
    repeat (3) sync();
    check("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
    check("rst_count", {28'd0, count_o}, 32'd0);
    check("rst_ferr", {31'd0, ferr_o}, 32'd0);
    check("rst_ovf", {31'd0, ovf_o}, 32'd0);
    check("rst_rdata", {24'd0, rdata_o}, 32'd0);
    rst_ni = 1'b1;
    repeat (5) sync();

    // 1: 0xA5, rvalid rises 153 cycles after t0 (edge 155 after the start-bit drive)
    send_head(8'hA5);
    rxd_i = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t1_not_yet", {31'd0, rvalid_o}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("t1_latency", {31'd0, rvalid_o}, 32'd1);
    check("t1_rdata", {24'd0, rdata_o}, 32'hA5);
    check("t1_count", {28'd0, count_o}, 32'd1);
    check("t1_ferr", {31'd0, ferr_o}, 32'd0);
    repeat (5) sync();
    pop_expect("t1_pop", 8'hA5);
    check("t1_empty_valid", {31'd0, rvalid_o}, 32'd0);
    check("t1_empty_count", {28'd0, count_o}, 32'd0);

    // 2: 4-cycle glitch is rejected, then a normal frame decodes
    rxd_i = 1'b0;
    repeat (4) sync();
    rxd_i = 1'b1;
    repeat (30) sync();
    check("t2_count", {28'd0, count_o}, 32'd0);
    check("t2_valid", {31'd0, rvalid_o}, 32'd0);
    check("t2_ferr", {31'd0, ferr_o}, 32'd0);
    send_frame(8'h5A);
    check("t2_next_count", {28'd0, count_o}, 32'd1);
    pop_expect("t2_next", 8'h5A);

    // 3: low stop bit then held-low line
    send_head(8'h3C);
    drive_bit(1'b0);
    check("t3_ferr_set", {31'd0, ferr_o}, 32'd1);
    check("t3_no_push", {28'd0, count_o}, 32'd0);
    repeat (40) sync();
    rxd_i = 1'b1;
    repeat (20) sync();
    check("t3_ferr_sticky", {31'd0, ferr_o}, 32'd1);
    check("t3_count", {28'd0, count_o}, 32'd0);
    send_frame(8'h11);
    check("t3_rx_count", {28'd0, count_o}, 32'd1);
    check("t3_ferr_kept", {31'd0, ferr_o}, 32'd1);
    pop_expect("t3_rx", 8'h11);
    pulse_clr();
    check("t3_ferr_clr", {31'd0, ferr_o}, 32'd0);

    // 3b: clear while in break; the held-low line must not re-frame
    send_head(8'h00);
    drive_bit(1'b0);
    check("t3b_ferr_set", {31'd0, ferr_o}, 32'd1);
    pulse_clr();
    check("t3b_ferr_clr", {31'd0, ferr_o}, 32'd0);
    repeat (24) sync();
    rxd_i = 1'b1;
    repeat (200) sync();
    check("t3b_single_ferr", {31'd0, ferr_o}, 32'd0);
    check("t3b_single_count", {28'd0, count_o}, 32'd0);

    // 4: nine bytes into an 8-deep FIFO
    for (int i = 1; i <= 9; i++) send_frame(8'(i));
    check("t4_count", {28'd0, count_o}, 32'd8);
    check("t4_ovf", {31'd0, ovf_o}, 32'd1);
    check("t4_ferr", {31'd0, ferr_o}, 32'd0);
    for (int i = 1; i <= 8; i++) pop_expect("t4_drain", 8'(i));
    check("t4_no_ninth", {31'd0, rvalid_o}, 32'd0);
    check("t4_empty_count", {28'd0, count_o}, 32'd0);
    pulse_clr();
    check("t4_ovf_clr", {31'd0, ovf_o}, 32'd0);

    // 5: pop on the exact stop-sample cycle of a push into a full FIFO
    for (int i = 1; i <= 8; i++) send_frame(8'(i));
    check("t5_full", {28'd0, count_o}, 32'd8);
    send_head(8'h09);
    rxd_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rready_i = 1'b1;
    @(posedge clk);
    #1;
    rready_i = 1'b0;
    repeat (5) sync();
    check("t5_ovf", {31'd0, ovf_o}, 32'd0);
    check("t5_count", {28'd0, count_o}, 32'd8);
    for (int i = 2; i <= 9; i++) pop_expect("t5_drain", 8'(i));
    check("t5_empty", {31'd0, rvalid_o}, 32'd0);

    // 6: reset during DATA of 0xF0 with three bytes queued
    send_frame(8'hC1);
    send_frame(8'hC2);
    send_frame(8'hC3);
    check("t6_queued", {28'd0, count_o}, 32'd3);
    drive_bit(1'b0);
    drive_bit(1'b0);
    repeat (8) sync();
    rst_ni = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, rvalid_o}, 32'd0);
    check("t6_rst_count", {28'd0, count_o}, 32'd0);
    check("t6_rst_rdata", {24'd0, rdata_o}, 32'd0);
    check("t6_rst_ferr", {31'd0, ferr_o}, 32'd0);
    check("t6_rst_ovf", {31'd0, ovf_o}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    rxd_i = 1'b1;
    repeat (8) sync();
    rst_ni = 1'b1;
    repeat (92) sync();
    check("t6_ignored_count", {28'd0, count_o}, 32'd0);
    check("t6_ignored_ferr", {31'd0, ferr_o}, 32'd0);
    send_frame(8'h7E);
    check("t6_rx_count", {28'd0, count_o}, 32'd1);
    check("t6_rx_ferr", {31'd0, ferr_o}, 32'd0);
    pop_expect("t6_rx", 8'h7E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- 8N1 UART receiver with a small receive FIFO and a ready/valid pop port.
- It is the receiving end of the serial link whose transmit side the SoC drives on `txd`. It provides the SoC's `rxd` input path, and the same block serves as the bench-side monitor that decodes console output.
- Sits between the external serial line and a memory-mapped peripheral wrapper on the data bus.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 1_000_000, line rate in bit/s. CPB = CLK_FREQ/BAUD (integer division) is clocks per bit; CPB must be at least 4, enforced by elaboration-time check.
- FIFO_DEPTH, 8, receive FIFO entries; must be a power of two and at least 2.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- rxd_i  in  1  serial line, idle high, asynchronous to clk_i.
- rdata_o  out  8  byte at FIFO head; valid only while rvalid_o=1.
- rvalid_o  out  1  FIFO non-empty.
- rready_i  in  1  consumer pop; a pop occurs when rvalid_o && rready_i.
- count_o  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- ferr_o  out  1  sticky framing error.
- ovf_o  out  1  sticky overflow (byte dropped because FIFO was full).
- clr_err_i  in  1  one-cycle pulse clears ferr_o and ovf_o.

Behaviour:
- Reset values (asynchronous, on rst_ni=0):
  - rvalid_o=0, count_o=0, ferr_o=0, ovf_o=0, rdata_o=0.
  - Synchronizer flops = 1; FSM = IDLE; bit counter and baud counter = 0.
- Reset mid-frame aborts the frame and empties the FIFO. No partial byte is ever pushed.
- Input synchronization: rxd_i passes through a 2-flop synchronizer; rx_s is the second flop. All decisions use rx_s only.
- FSM states:
  - IDLE: on rx_s=0 → START, baud counter loaded. Call this cycle t0.
  - START: waits CPB/2 cycles, then samples rx_s. If 0 → DATA. If 1, it was a glitch → IDLE, nothing flagged.
  - DATA: samples every CPB cycles, 8 samples, LSB first, into a shift register → STOP.
  - STOP: samples after CPB cycles, at t0 + CPB/2 + 9*CPB.
    - Sample 1: push the byte → IDLE.
    - Sample 0: set ferr_o, drop the byte → BREAK.
  - BREAK: waits for rx_s=1 → IDLE. A held-low line produces exactly one ferr event, not repeated frames.
- Push timing: the pushed byte is visible at the FIFO head, rvalid_o=1, on the cycle after the stop sample if the FIFO was empty. Push-to-visible latency is 1 cycle.
- FIFO:
  - Circular buffer with read and write pointers of $clog2(FIFO_DEPTH) bits, wrapping naturally.
  - count_o is tracked separately (0..FIFO_DEPTH). rdata_o is driven directly from the head entry.
- Push and pop interaction:
  - Push while full with no pop: byte dropped, ovf_o set, contents unchanged.
  - Push while full with a simultaneous pop: push accepted, count stays FIFO_DEPTH, no overflow.
  - Push and pop on the same cycle when empty: not possible, because rvalid_o=0.
  - Push and pop on the same cycle when non-empty: both happen, count unchanged.
- Pop while empty (rready_i=1, rvalid_o=0): no effect.
- Error flags: clr_err_i has priority over a same-cycle set, so an event coincident with clr_err_i is lost by design. Flags do not block reception.
- Frame timing: back-to-back frames are accepted. After STOP returns to IDLE, the next falling edge may start a new frame immediately.

Test Plan:
1. CLK_FREQ=16_000_000, BAUD=1_000_000 (CPB=16); send 0xA5 with a valid stop bit → rvalid_o rises exactly 153 cycles after t0, rdata_o=0xA5, count_o=1, ferr_o=0; pulse rready_i → rvalid_o=0, count_o=0.
2. Low glitch on rxd_i of 4 cycles, then idle → FSM returns to IDLE, no push, ferr_o=0, count_o stays 0.
3. Send 0x3C with stop bit forced low, line then held low 40 cycles, then high → ferr_o=1, count_o=0, single error event; send 0x11 → received normally, ferr_o stays 1 until a clr_err_i pulse clears it.
4. Send 9 bytes 0x01..0x09 with rready_i=0, FIFO_DEPTH=8 → count_o=8, ovf_o=1; drain returns 0x01..0x08 in order, 0x09 absent.
5. FIFO full; assert rready_i on the exact cycle of the 9th byte's stop sample → no overflow, count_o stays 8, drain yields 0x02..0x09.
6. Assert rst_ni=0 midway through the DATA bits of a frame with 3 bytes queued → all outputs at reset values; the remainder of the frame is ignored until its stop bit passes; the next full frame 0x7E is received correctly.
